// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer for the 8-bit computer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes from the registered state and the IR opcode, and adds
// run/halt control, a memory-timeout fault and a retired-instruction count.
module seq_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       instr,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             jctrl,
    output logic             jrctrl,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             link,
    output logic [2:0]       ALUop,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SL   = 4'd6;
    localparam logic [3:0] OP_SR   = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_ADDI = 4'd10;
    localparam logic [3:0] OP_JR   = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_JAL  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Last wait count before the limit; a miss here means the limit is reached.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ALU function for an opcode.
    function automatic logic [2:0] alu_op_f(input logic [3:0] op);
        logic [2:0] f;
        case (op)
            OP_ADD, OP_ADDI: f = 3'b111;
            OP_NAND:         f = 3'b001;
            OP_SLT, OP_SLTU: f = 3'b010;
            OP_SL:           f = 3'b011;
            OP_SR:           f = 3'b100;
            OP_BEQ:          f = 3'b101;
            default:         f = 3'b000;
        endcase
        return f;
    endfunction

    // Undefined opcodes trap in DECODE.
    function automatic logic is_illegal_f(input logic [3:0] op);
        logic r;
        case (op)
            4'd1, 4'd3, 4'd14: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [7:0]       tmo_r;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s;
    logic             tmo_hit_s;
    logic [2:0]       retire_nxt_s;

    assign state   = state_r;
    assign instret = instret_r;

    // Timeout fires when this wait cycle would bring the counter to the limit.
    always_comb begin
        tmo_hit_s    = mem_req && !mem_ack && (tmo_r == TMO_LAST);
        retire_nxt_s = run ? S_FETCH : S_IDLE;
    end

    // Next-state, strobe and retirement decode from state, opcode and handshake.
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        mem_req     = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        jctrl       = 1'b0;
        jrctrl      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        link        = 1'b0;
        ALUop       = 3'b000;
        halted      = 1'b0;
        fault       = 1'b0;
        illegal     = 1'b0;
        case (state_r)
            S_IDLE: begin
                halted = 1'b1;
                if (run) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                memread = 1'b1;
                if (mem_ack) begin
                    ir_load     = 1'b1;
                    pc_inc      = 1'b1;
                    state_nxt_s = S_DECODE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = S_FAULT;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (instr == OP_HALT) begin
                    // Halt always parks, even with run still high.
                    retire_s    = 1'b1;
                    state_nxt_s = S_IDLE;
                end else if (is_illegal_f(instr)) begin
                    illegal     = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUop = alu_op_f(instr);
                case (instr)
                    OP_ADD, OP_NAND, OP_SLT, OP_SLTU, OP_SL, OP_SR, OP_ADDI: begin
                        state_nxt_s = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        state_nxt_s = S_MEM;
                    end
                    OP_JR: begin
                        jrctrl      = 1'b1;
                        pc_load     = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = retire_nxt_s;
                    end
                    OP_BEQ: begin
                        jctrl       = 1'b1;
                        pc_load     = zero;
                        retire_s    = 1'b1;
                        state_nxt_s = retire_nxt_s;
                    end
                    OP_JAL: begin
                        jctrl       = 1'b1;
                        pc_load     = 1'b1;
                        regwrite    = 1'b1;
                        link        = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = retire_nxt_s;
                    end
                    default: begin
                        // IR changed under us; park rather than guess.
                        state_nxt_s = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (instr == OP_LW) begin
                    memread  = 1'b1;
                    memwrite = 1'b0;
                end else begin
                    memread  = 1'b0;
                    memwrite = 1'b1;
                end
                if (mem_ack) begin
                    if (instr == OP_LW) begin
                        state_nxt_s = S_WB;
                    end else begin
                        retire_s    = 1'b1;
                        state_nxt_s = retire_nxt_s;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = S_FAULT;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB: begin
                ALUop       = alu_op_f(instr);
                regwrite    = 1'b1;
                memtoreg    = (instr == OP_LW);
                retire_s    = 1'b1;
                state_nxt_s = retire_nxt_s;
            end
            S_FAULT: begin
                fault       = 1'b1;
                state_nxt_s = S_FAULT;
            end
            default: begin
                // Unused encoding: recover to a safe parked state.
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: cleared on every state change, counts unacknowledged requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_r <= 8'd0;
        end else if (state_nxt_s != state_r) begin
            tmo_r <= 8'd0;
        end else if (mem_req && !mem_ack) begin
            tmo_r <= tmo_r + 8'd1;
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_ONE;
        end else begin
            instret_r <= instret_r;
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed testbench for seq_ctrl. A second instance with a 4-bit counter
// shares the stimulus so the retired-count wrap can be reached quickly.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, mem_ack;
    logic [3:0]  instr;
    logic        mem_req, ir_load, pc_inc, pc_load, jctrl, jrctrl;
    logic        memread, memwrite, memtoreg, regwrite, link;
    logic [2:0]  ALUop, state;
    logic        halted, fault, illegal;
    logic [15:0] instret;

    logic        w_mem_req, w_ir_load, w_pc_inc, w_pc_load, w_jctrl, w_jrctrl;
    logic        w_memread, w_memwrite, w_memtoreg, w_regwrite, w_link;
    logic [2:0]  w_ALUop, w_state;
    logic        w_halted, w_fault, w_illegal;
    logic [3:0]  w_instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .jctrl(jctrl), .jrctrl(jrctrl),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .link(link), .ALUop(ALUop), .state(state),
        .halted(halted), .fault(fault), .illegal(illegal), .instret(instret)
    );

    seq_ctrl #(.CNT_W(4), .MEM_TIMEOUT(15)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
        .mem_ack(mem_ack), .mem_req(w_mem_req), .ir_load(w_ir_load),
        .pc_inc(w_pc_inc), .pc_load(w_pc_load), .jctrl(w_jctrl),
        .jrctrl(w_jrctrl), .memread(w_memread), .memwrite(w_memwrite),
        .memtoreg(w_memtoreg), .regwrite(w_regwrite), .link(w_link),
        .ALUop(w_ALUop), .state(w_state), .halted(w_halted), .fault(w_fault),
        .illegal(w_illegal), .instret(w_instret)
    );

    // Advance one rising edge and move away from it.
    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; instr = 4'd0; zero = 1'b0; mem_ack = 1'b0;
        adv(); adv();
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_aluop", 32'(ALUop), 32'd0);

        // ALU add with immediate acks: 0,1,2,3,5,1
        rst_n = 1'b1; run = 1'b1; mem_ack = 1'b1; instr = 4'd0; #1;
        chk("add_idle", 32'(state), 32'd0);
        adv(); #1;
        chk("add_fetch", 32'(state), 32'd1);
        chk("add_fetch_memread", 32'(memread), 32'd1);
        chk("add_fetch_irload", 32'(ir_load), 32'd1);
        chk("add_fetch_pcinc", 32'(pc_inc), 32'd1);
        chk("add_fetch_aluop", 32'(ALUop), 32'd0);
        adv(); #1;
        chk("add_decode", 32'(state), 32'd2);
        chk("add_decode_regwrite", 32'(regwrite), 32'd0);
        adv(); #1;
        chk("add_exec", 32'(state), 32'd3);
        chk("add_exec_aluop", 32'(ALUop), 32'd7);
        chk("add_exec_regwrite", 32'(regwrite), 32'd0);
        adv(); #1;
        chk("add_wb", 32'(state), 32'd5);
        chk("add_wb_aluop", 32'(ALUop), 32'd7);
        chk("add_wb_regwrite", 32'(regwrite), 32'd1);
        adv(); #1;
        chk("add_refetch", 32'(state), 32'd1);
        chk("add_instret", 32'(instret), 32'd1);

        // lw with three wait cycles in MEM
        instr = 4'd8;
        adv(); adv(); #1;
        chk("lw_exec", 32'(state), 32'd3);
        chk("lw_exec_aluop", 32'(ALUop), 32'd0);
        adv(); mem_ack = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait_state", 32'(state), 32'd4);
            chk("lw_mem_wait_req", 32'({mem_req, memread, memwrite}), 32'b110);
            adv(); #1;
        end
        mem_ack = 1'b1; #1;
        chk("lw_mem_ack_state", 32'(state), 32'd4);
        chk("lw_mem_ack_req", 32'({mem_req, memread, ir_load}), 32'b110);
        adv(); #1;
        chk("lw_wb", 32'(state), 32'd5);
        chk("lw_wb_strobes", 32'({memtoreg, regwrite}), 32'b11);
        adv(); #1;
        chk("lw_instret", 32'(instret), 32'd2);

        // beq, not taken then taken
        instr = 4'd12; zero = 1'b0;
        adv(); adv(); #1;
        chk("beq_exec", 32'(state), 32'd3);
        chk("beq_aluop", 32'(ALUop), 32'd5);
        chk("beq_nt", 32'({jctrl, pc_load}), 32'b10);
        zero = 1'b1; #1;
        chk("beq_t", 32'({jctrl, pc_load}), 32'b11);
        adv(); #1;
        chk("beq_refetch", 32'(state), 32'd1);
        chk("beq_instret", 32'(instret), 32'd3);

        // jal
        instr = 4'd13;
        adv(); adv(); #1;
        chk("jal_exec", 32'({regwrite, link, pc_load, jctrl, jrctrl}), 32'b11110);
        adv(); #1;
        chk("jal_instret", 32'(instret), 32'd4);

        // jr
        instr = 4'd11;
        adv(); adv(); #1;
        chk("jr_exec", 32'({jrctrl, pc_load, jctrl, regwrite}), 32'b1100);
        adv(); #1;
        chk("jr_instret", 32'(instret), 32'd5);

        // sw with immediate ack
        instr = 4'd9;
        adv(); adv(); adv(); #1;
        chk("sw_mem", 32'({state, mem_req, memread, memwrite}), 32'b100101);
        adv(); #1;
        chk("sw_refetch", 32'(state), 32'd1);
        chk("sw_instret", 32'(instret), 32'd6);

        // illegal 14 then halt 15
        instr = 4'd14;
        adv(); #1;
        chk("ill_pulse", 32'(illegal), 32'd1);
        adv(); #1;
        chk("ill_refetch", 32'(state), 32'd1);
        chk("ill_no_pulse", 32'(illegal), 32'd0);
        chk("ill_instret", 32'(instret), 32'd6);
        instr = 4'd15;
        adv(); #1;
        chk("halt_decode_illegal", 32'(illegal), 32'd0);
        adv(); #1;
        chk("halt_idle", 32'({state, halted}), 32'b0001);
        chk("halt_instret", 32'(instret), 32'd7);
        adv(); #1;
        chk("halt_restart", 32'(state), 32'd1);

        // nand with run dropped: retire to IDLE
        instr = 4'd2; run = 1'b0;
        adv(); adv(); #1;
        chk("nand_aluop", 32'(ALUop), 32'd1);
        adv(); adv(); #1;
        chk("nand_idle", 32'(state), 32'd0);
        chk("nand_instret", 32'(instret), 32'd8);
        adv(); #1;
        chk("stray_ack_idle", 32'({state, ir_load, mem_req}), 32'd0);

        // Timeout in FETCH: 15 wait cycles then FAULT
        run = 1'b1; mem_ack = 1'b0;
        adv(); #1;
        for (int i = 0; i < 15; i++) begin
            chk("tmo_fetch_wait", 32'(state), 32'd1);
            adv(); #1;
        end
        chk("tmo_fault_state", 32'(state), 32'd6);
        chk("tmo_fault_outs", 32'({fault, halted, mem_req, memread}), 32'b1000);
        run = 1'b0;
        adv(); #1;
        chk("tmo_fault_run0", 32'(state), 32'd6);
        run = 1'b1; mem_ack = 1'b1;
        adv(); #1;
        chk("tmo_fault_run1", 32'({state, ir_load}), 32'b1100);
        rst_n = 1'b0;
        adv(); #1;
        chk("tmo_reset_state", 32'(state), 32'd0);
        chk("tmo_reset_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;

        // Ack on the 15th wait cycle wins over the timeout
        mem_ack = 1'b0; instr = 4'd0;
        adv(); #1;
        for (int i = 0; i < 14; i++) begin
            chk("lim_fetch_wait", 32'(state), 32'd1);
            adv(); #1;
        end
        mem_ack = 1'b1; #1;
        chk("lim_ack_irload", 32'(ir_load), 32'd1);
        adv(); #1;
        chk("lim_decode", 32'(state), 32'd2);
        adv(); adv(); adv(); #1;
        chk("lim_instret", 32'(instret), 32'd1);

        // Reset during sw in MEM drops the write
        instr = 4'd9;
        adv(); adv(); adv(); #1;
        chk("swrst_mem_write", 32'({state, memwrite}), 32'b1001);
        rst_n = 1'b0;
        adv(); #1;
        chk("swrst_write_dropped", 32'({state, memwrite, mem_req}), 32'd0);
        chk("swrst_instret", 32'(instret), 32'd0);
        chk("swrst_wide_instret", 32'(w_instret), 32'd0);
        rst_n = 1'b1;

        // Counter wrap: jr retirements, 3 cycles each, on the 4-bit instance
        instr = 4'd11; run = 1'b1; mem_ack = 1'b1;
        adv(); #1;
        for (int i = 0; i < 45; i++) adv();
        #1;
        chk("wrap_pre_main", 32'(instret), 32'd15);
        chk("wrap_pre_small", 32'(w_instret), 32'hF);
        adv(); adv(); adv(); #1;
        chk("wrap_post_main", 32'(instret), 32'd16);
        chk("wrap_post_small", 32'(w_instret), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle instruction sequencer for the 8-bit computer. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath strobes (`ALUop`, `memread`, `memwrite`, `memtoreg`, `jctrl`, `jrctrl`, plus PC, IR and register-file enables) from the current state and the 4-bit opcode. It sits between the single-port instruction/data memory handshake and the datapath, and adds halt/run control, a memory-timeout fault and a retired-instruction counter.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `MEM_TIMEOUT`, 15, max cycles `mem_req` may wait for `mem_ack` (1..255)
- `clk` in 1: single clock; all state changes on rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `run` in 1: start from IDLE; sampled at each instruction retirement
- `instr` in 4: opcode from IR; valid from DECODE onward
- `zero` in 1: ALU zero flag; sampled in EXEC for beq
- `mem_ack` in 1: memory access complete (single-cycle pulse or level)
- `mem_req` out 1: memory access request
- `ir_load` out 1: load IR from memory data
- `pc_inc` out 1: PC <= PC+1
- `pc_load` out 1: PC <= jump/branch target
- `jctrl`, `jrctrl` out 1 each: jump/branch target select, jump-register select
- `memread`, `memwrite`, `memtoreg` out 1 each: memory read, memory write, write-back from memory
- `regwrite` out 1: register-file write enable
- `link` out 1: write-back selects return address (jal)
- `ALUop` out 3: ALU function
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6
- `halted` out 1: high in IDLE
- `fault` out 1: high in FAULT
- `illegal` out 1: one-cycle pulse on an undefined opcode
- `instret` out CNT_W: retired-instruction count

## Operation
- **ALUop by opcode:** 0 add=111; 2 nand=001; 4,5 slt=010; 6 sl=011; 7 sr=100; 10 addi=111; 12 beq=101; all others 000. `ALUop` is driven in EXEC and WB and is 000 elsewhere.
- **IDLE:** `halted`=1, all strobes 0. If `run`=1, go to FETCH.
- **FETCH:** `mem_req`=1, `memread`=1. In the cycle `mem_ack`=1, also assert `ir_load`=1 and `pc_inc`=1, then go to DECODE. Otherwise stay.
- **DECODE:** single cycle, no strobes.
  - Opcode 15 (halt) retires and goes to IDLE.
  - Opcodes 1, 3, 14: pulse `illegal`, do not retire, go to FETCH.
  - All other opcodes go to EXEC.
- **EXEC:**
  - ALU ops (0,2,4,5,6,7,10) go to WB.
  - 8 (lw) and 9 (sw) go to MEM.
  - 11 (jr): `jrctrl`=1, `pc_load`=1, retire.
  - 12 (beq): `jctrl`=1, `pc_load`=`zero`, retire.
  - 13 (jal): `jctrl`=1, `pc_load`=1, `regwrite`=1, `link`=1, retire.
- **MEM:** `mem_req`=1, with `memread`=1 (lw) or `memwrite`=1 (sw).
  - On `mem_ack`, lw goes to WB.
  - On `mem_ack`, sw retires.
- **WB:** `regwrite`=1; lw adds `memtoreg`=1. Retire.
- **Retire:** `instret` += 1, wrapping modulo 2^CNT_W. Next state is FETCH if `run`=1, else IDLE. The exception is halt (15), which always goes to IDLE.
- **Timeout:** a counter clears on entry to FETCH/MEM and increments each cycle with `mem_req`=1 and `mem_ack`=0. When it reaches `MEM_TIMEOUT`, go to FAULT.
- **FAULT:** `fault`=1, all strobes 0, `run` and `mem_ack` ignored. Exit only by reset.
- **Opcode sampling:** `instr` is sampled every cycle from DECODE to WB. The datapath holds the IR stable, so the block stores no copy.

## Timing
- **Reset:** `rst_n`=0 at a rising edge puts the block in IDLE, with `instret`=0 and the timeout counter at 0. All outputs are 0 except `halted`=1 and `state`=0. This applies mid-instruction, including MEM with `mem_ack` high; a pending sw write is dropped.
- **Output type:** all outputs are combinational from the registered state, `instr`, `zero` and `mem_ack`. `ir_load`, `pc_inc` and the FETCH/MEM exits are qualified by `mem_ack` in the same cycle.
- **Minimum latency, `mem_ack` on the first request cycle:**
  - ALU op: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - jr, beq, jal: 3 cycles.
  - halt: 2 cycles.
- **Memory wait:** each wait cycle adds one cycle.
- **Ack exactly at the limit:** if `mem_ack`=1 in the same cycle the counter would reach `MEM_TIMEOUT`, the ack wins and no fault occurs.
- **Stray ack:** `mem_ack` outside FETCH/MEM is ignored.
- **Run vs. halt:** `run`=1 coincident with a halt retirement still goes to IDLE. The block restarts on the next cycle if `run` is still 1.

## Test plan
- **Reset, then `run`=1, ack always 1, opcode 0:** state sequence 0,1,2,3,5,1. `ALUop`=111 in EXEC/WB, `regwrite` high only in WB, `instret`=1.
- **lw (8) with `mem_ack` delayed 3 cycles in MEM:** `memread`+`mem_req` held 4 cycles, then WB with `memtoreg`=1 and `regwrite`=1. Total 8 cycles.
- **beq (12):** with `zero`=0, `pc_load`=0 and `jctrl`=1. With `zero`=1, `pc_load`=1. `ALUop`=101. jal (13): `regwrite`, `link` and `pc_load` all high in EXEC.
- **Opcode 14 then 15:** `illegal` pulses once and `instret` is unchanged. Halt then gives `halted`=1 and `instret`+1.
- **`mem_ack` held 0 in FETCH, `MEM_TIMEOUT`=15:** FAULT after 15 cycles, `fault`=1. `run` toggling has no effect; `rst_n`=0 for one cycle returns to IDLE.
- **`instret` preloaded to 0xFFFF via 65535 retirements (or force):** the next retirement wraps it to 0x0000. Reset asserted in MEM during sw: `memwrite` drops the next cycle.
